// File: rtl/irq_sched_pkg.sv
// Shared types and defaults for the irq_sched interrupt scheduler.
package irq_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_ASSERT = 2'd2,
    ST_GAP    = 2'd3
  } state_e;

  localparam logic [31:0] ACK_ADDR_DEFAULT = 32'h0000_7f20;

  typedef struct packed {
    logic        valid;
    logic [29:0] pc;
  } entry_t;

endpackage

// File: rtl/irq_sched_table.sv
// Trigger table: DEPTH word-PC entries with a write port, a valid-clear port,
// one read port and an any-valid reduction.
module irq_sched_table
  import irq_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_wr_en,
  input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
  input  entry_t                   i_wr_entry,
  input  logic                     i_clr_en,
  input  logic [$clog2(DEPTH)-1:0] i_clr_idx,
  input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
  output entry_t                   o_rd_entry,
  output logic                     o_any_valid
);

  entry_t r_mem [DEPTH];

  // NOTE: only the valid bits need a reset; the pc fields are don't-care
  // while invalid. The write is placed after the clear so that, as the last
  // non-blocking assignment, it wins when both hit the same entry.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i].valid <= 1'b0;
    end else begin
      if (i_clr_en) r_mem[i_clr_idx].valid <= 1'b0;
      if (i_wr_en)  r_mem[i_wr_idx]        <= i_wr_entry;
    end
  end

  assign o_rd_entry = r_mem[i_rd_idx];

  always_comb begin
    o_any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) o_any_valid = o_any_valid | r_mem[i].valid;
  end

endmodule

// File: rtl/irq_sched.sv
// PC-triggered interrupt scheduler for the MIPS core's interrupt input.
// Define IRQ_SCHED_TIMEOUT_EN to add the unacknowledged-interrupt watchdog.
module irq_sched
  import irq_sched_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [31:0] ACK_ADDR    = ACK_ADDR_DEFAULT,
  parameter int unsigned GAP_CYC     = 8,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sched_en,
  input  logic [31:0]              macroscopic_pc,
  input  logic [31:0]              m_int_addr,
  input  logic [3:0]               m_int_byteen,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_idx,
  input  logic [31:0]              cfg_pc,
  input  logic                     cfg_valid,
  output logic                     interrupt,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic [15:0]              fired_cnt,
  output logic                     timeout
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned GW = $clog2(GAP_CYC + 1);

  state_e        r_state, w_state_nxt;
  logic [IW-1:0] r_cur_idx;
  logic [GW-1:0] r_gap_cnt;
  logic [15:0]   r_fired_cnt;
  entry_t        w_cfg_entry, w_cur_entry;
  logic          w_any_valid, w_ack, w_match, w_expire;
  logic          w_release, w_acked, w_adv_idx;
  logic          w_unused;

  assign w_unused    = ^{macroscopic_pc[1:0], cfg_pc[1:0]};
  assign w_cfg_entry = {cfg_valid, cfg_pc[31:2]};
  assign w_ack       = (|m_int_byteen) && ((m_int_addr & ~32'd3) == ACK_ADDR);
  assign w_match     = w_cur_entry.valid && (macroscopic_pc[31:2] == w_cur_entry.pc);

  irq_sched_table #(.DEPTH(DEPTH)) u_table (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (cfg_we),
    .i_wr_idx   (cfg_idx),
    .i_wr_entry (w_cfg_entry),
    .i_clr_en   (w_release),
    .i_clr_idx  (r_cur_idx),
    .i_rd_idx   (r_cur_idx),
    .o_rd_entry (w_cur_entry),
    .o_any_valid(w_any_valid)
  );

`ifdef IRQ_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_wd_cnt;
  logic          r_timeout;

  // Watchdog holds the count of ASSERT cycles already spent, so it expires
  // in the TIMEOUT_CYC-th cycle of the request.
  assign w_expire = (r_wd_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == ST_ASSERT && w_state_nxt == ST_ASSERT) r_wd_cnt <= r_wd_cnt + TW'(1);
      else                                                  r_wd_cnt <= '0;
      if (w_release && !w_ack) r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  localparam int unsigned unused_timeout_cyc = TIMEOUT_CYC;
  assign w_expire = 1'b0;
  assign timeout  = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path
  // through the case leaves a signal unassigned (which would infer a latch).
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_acked     = 1'b0;
    w_adv_idx   = 1'b0;
    if (!sched_en) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:  if (w_any_valid) w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (!w_any_valid)            w_state_nxt = ST_IDLE;
          else if (!w_cur_entry.valid) w_adv_idx   = 1'b1;
          else if (w_match)            w_state_nxt = ST_ASSERT;
        end
        ST_ASSERT: begin
          if (w_ack || w_expire) begin
            w_state_nxt = ST_GAP;
            w_release   = 1'b1;
            w_adv_idx   = 1'b1;
            w_acked     = w_ack;
          end
        end
        ST_GAP:   if (r_gap_cnt == '0) w_state_nxt = ST_ARMED;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cur_idx   <= '0;
      r_gap_cnt   <= '0;
      r_fired_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_adv_idx) r_cur_idx   <= r_cur_idx + IW'(1);
      if (w_acked)   r_fired_cnt <= r_fired_cnt + 16'd1;
      if (w_release)                                r_gap_cnt <= GW'(GAP_CYC);
      else if (r_state == ST_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GW'(1);
    end
  end

  assign interrupt = (r_state == ST_ASSERT);
  assign busy      = (r_state == ST_ASSERT) || (r_state == ST_GAP);
  assign cur_idx   = r_cur_idx;
  assign fired_cnt = r_fired_cnt;

endmodule

// File: tb/tb_irq_sched.sv
// Self-checking bench for irq_sched: directed vector table, hand-written
// multi-cycle sequences and random stimulus against a behavioural model.
module tb_irq_sched;

  localparam int          DEPTH = 4;
  localparam int          GAP   = 8;
  localparam int          TOUT  = 16;
  localparam logic [31:0] ACKA  = 32'h0000_7f20;
`ifdef IRQ_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        reset, sched_en, cfg_we, cfg_valid;
  logic [31:0] macroscopic_pc, m_int_addr, cfg_pc;
  logic [3:0]  m_int_byteen;
  logic [1:0]  cfg_idx;
  logic        interrupt, busy, timeout;
  logic [1:0]  cur_idx;
  logic [15:0] fired_cnt;

  irq_sched #(.DEPTH(DEPTH), .ACK_ADDR(ACKA), .GAP_CYC(GAP), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .sched_en(sched_en), .macroscopic_pc(macroscopic_pc),
    .m_int_addr(m_int_addr), .m_int_byteen(m_int_byteen), .cfg_we(cfg_we),
    .cfg_idx(cfg_idx), .cfg_pc(cfg_pc), .cfg_valid(cfg_valid),
    .interrupt(interrupt), .busy(busy), .cur_idx(cur_idx),
    .fired_cnt(fired_cnt), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef enum {P_OFF, P_SCAN, P_IRQ, P_HOLDOFF} phase_e;
  phase_e      m_phase = P_OFF;
  bit          m_valid [DEPTH];
  int unsigned m_pc    [DEPTH];
  int          m_idx = 0, m_fired = 0, m_gap_left = 0, m_age = 0;
  bit          m_timeout = 0;

  task automatic model_step();
    bit any, ack;
    int clr;
    if (!reset) begin
      m_phase = P_OFF; m_idx = 0; m_fired = 0; m_timeout = 0;
      foreach (m_valid[i]) m_valid[i] = 0;
      return;
    end
    any = 0;
    foreach (m_valid[i]) any |= m_valid[i];
    ack = (m_int_byteen != 0) && ((m_int_addr >> 2) == (ACKA >> 2));
    clr = -1;
    if (!sched_en) m_phase = P_OFF;
    else case (m_phase)
      P_OFF:  if (any) m_phase = P_SCAN;
      P_SCAN: begin
        if (!any) m_phase = P_OFF;
        else if (!m_valid[m_idx]) m_idx = (m_idx + 1) % DEPTH;
        else if ((macroscopic_pc >> 2) == m_pc[m_idx]) begin m_phase = P_IRQ; m_age = 0; end
      end
      P_IRQ: begin
        m_age++;
        if (ack || (TO_EN && m_age == TOUT)) begin
          if (ack) m_fired = (m_fired + 1) % 65536;
          else     m_timeout = 1;
          clr = m_idx;
          m_idx = (m_idx + 1) % DEPTH;
          m_phase = P_HOLDOFF;
          m_gap_left = GAP + 1;
        end
      end
      P_HOLDOFF: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = P_SCAN;
      end
    endcase
    if (clr >= 0) m_valid[clr] = 0;
    if (cfg_we) begin m_valid[cfg_idx] = cfg_valid; m_pc[cfg_idx] = cfg_pc >> 2; end
  endtask

  // One clock: model advances on the same inputs the DUT samples, then compare.
  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check("mdl_irq",     interrupt, (m_phase == P_IRQ));
    check("mdl_busy",    busy,      (m_phase == P_IRQ || m_phase == P_HOLDOFF));
    check("mdl_idx",     cur_idx,   m_idx);
    check("mdl_fired",   fired_cnt, m_fired);
    check("mdl_timeout", timeout,   m_timeout);
  endtask

  task automatic idle_inputs();
    reset = 1; sched_en = 1; macroscopic_pc = 0; m_int_addr = 0; m_int_byteen = 0;
    cfg_we = 0; cfg_idx = 0; cfg_pc = 0; cfg_valid = 0;
  endtask

  task automatic do_reset();
    idle_inputs(); reset = 0; step(); reset = 1;
  endtask

  task automatic cfg(input logic [1:0] ix, input logic [31:0] pc, input bit v);
    idle_inputs(); cfg_we = 1; cfg_idx = ix; cfg_pc = pc; cfg_valid = v; step(); cfg_we = 0;
  endtask

  task automatic wait_irq(input int max_cyc, output int n);
    n = 0;
    while (interrupt !== 1'b1 && n < max_cyc) begin step(); n++; end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          rst_n, en, we, cv;
    logic [31:0] pc, ad, cp;
    logic [3:0]  be;
    logic [1:0]  ix;
    bit          e_irq, e_busy;
    logic [1:0]  e_idx;
    logic [15:0] e_fired;
  } vec_t;

  function automatic vec_t mk(bit r, logic [31:0] pc, logic [31:0] ad, logic [3:0] be,
                              bit we, logic [1:0] ix, logic [31:0] cp, bit cv,
                              bit ei, bit eb, logic [1:0] eix, logic [15:0] ef);
    vec_t v;
    v.rst_n = r; v.en = 1; v.pc = pc; v.ad = ad; v.be = be; v.we = we; v.ix = ix;
    v.cp = cp; v.cv = cv; v.e_irq = ei; v.e_busy = eb; v.e_idx = eix; v.e_fired = ef;
    return v;
  endfunction

  vec_t vecs[$];
  int   n;

  initial begin
    idle_inputs();
    //                 rst pc        addr      be    we ix cfg_pc   cv  irq busy idx fired
    vecs.push_back(mk(0, 0,        0,        4'h0, 0, 0, 0,       0,  0, 0, 0, 0)); // reset
    vecs.push_back(mk(1, 0,        0,        4'h0, 1, 0, 32'h3010, 1, 0, 0, 0, 0)); // cfg entry0
    vecs.push_back(mk(1, 0,        0,        4'h0, 0, 0, 0,       0,  0, 0, 0, 0)); // -> ARMED
    vecs.push_back(mk(1, 32'h3012, 0,        4'h0, 0, 0, 0,       0,  1, 1, 0, 0)); // match, low bits ignored
    vecs.push_back(mk(1, 0,        32'h7f24, 4'hf, 0, 0, 0,       0,  1, 1, 0, 0)); // wrong addr
    vecs.push_back(mk(1, 0,        32'h7f20, 4'h0, 0, 0, 0,       0,  1, 1, 0, 0)); // byteen 0
    vecs.push_back(mk(1, 0,        32'h7f20, 4'hf, 0, 0, 0,       0,  0, 1, 1, 1)); // ack
    vecs.push_back(mk(1, 32'h3010, 0,        4'h0, 0, 0, 0,       0,  0, 1, 1, 1)); // gap
    vecs.push_back(mk(1, 0,        32'h7f23, 4'h2, 0, 0, 0,       0,  0, 1, 1, 1)); // ack in gap ignored
    for (int k = 0; k < 6; k++)
      vecs.push_back(mk(1, 0, 0, 4'h0, 0, 0, 0, 0, 0, 1, 1, 1));                    // gap cnt 6..1
    vecs.push_back(mk(1, 0,        0,        4'h0, 0, 0, 0,       0,  0, 0, 1, 1)); // -> ARMED
    vecs.push_back(mk(1, 0,        0,        4'h0, 0, 0, 0,       0,  0, 0, 1, 1)); // no valid -> IDLE
    vecs.push_back(mk(1, 0,        32'h7f20, 4'hf, 0, 0, 0,       0,  0, 0, 1, 1)); // ack in IDLE
    vecs.push_back(mk(1, 32'h3010, 0,        4'h0, 0, 0, 0,       0,  0, 0, 1, 1)); // cleared entry

    foreach (vecs[k]) begin
      reset = vecs[k].rst_n; sched_en = vecs[k].en; macroscopic_pc = vecs[k].pc;
      m_int_addr = vecs[k].ad; m_int_byteen = vecs[k].be; cfg_we = vecs[k].we;
      cfg_idx = vecs[k].ix; cfg_pc = vecs[k].cp; cfg_valid = vecs[k].cv;
      step();
      check($sformatf("vec%0d_irq", k),   interrupt, vecs[k].e_irq);
      check($sformatf("vec%0d_busy", k),  busy,      vecs[k].e_busy);
      check($sformatf("vec%0d_idx", k),   cur_idx,   vecs[k].e_idx);
      check($sformatf("vec%0d_fired", k), fired_cnt, vecs[k].e_fired);
      check($sformatf("vec%0d_tout", k),  timeout,   0);
    end

    // Two entries: match during gap ignored, re-arm exactly 10 cycles after ack.
    do_reset();
    cfg(0, 32'h3010, 1);
    cfg(1, 32'h3020, 1);
    idle_inputs(); macroscopic_pc = 32'h3010; step();
    check("seqA_irq1", interrupt, 1);
    idle_inputs(); m_int_addr = ACKA; m_int_byteen = 4'hf; step();
    check("seqA_fired1", fired_cnt, 1);
    check("seqA_idx1", cur_idx, 1);
    idle_inputs(); step(); step();
    macroscopic_pc = 32'h3020; step();
    check("seqA_gap_ignore", interrupt, 0);
    wait_irq(30, n);
    check("seqA_rearm_lat", n + 3, 10);
    idle_inputs(); m_int_addr = ACKA; m_int_byteen = 4'h8; step();
    check("seqA_fired2", fired_cnt, 2);
    check("seqA_idx2", cur_idx, 2);

    // sched_en drop mid-ASSERT, re-fire from same index, ack+cfg_we collision.
    do_reset();
    cfg(0, 32'h3010, 1);
    idle_inputs(); step();
    macroscopic_pc = 32'h3010; step();
    check("seqB_irq", interrupt, 1);
    sched_en = 0; m_int_addr = ACKA; m_int_byteen = 4'hf; step();
    check("seqB_en_irq", interrupt, 0);
    check("seqB_en_busy", busy, 0);
    check("seqB_en_fired", fired_cnt, 0);
    idle_inputs(); macroscopic_pc = 32'h3010; step();
    check("seqB_rearm", interrupt, 0);
    step();
    check("seqB_refire", interrupt, 1);
    check("seqB_refire_idx", cur_idx, 0);
    cfg_we = 1; cfg_idx = 0; cfg_pc = 32'h3040; cfg_valid = 1; m_int_addr = ACKA; m_int_byteen = 4'hf;
    step();
    check("seqB_coll_fired", fired_cnt, 1);
    check("seqB_coll_idx", cur_idx, 1);
    idle_inputs(); macroscopic_pc = 32'h3040;
    wait_irq(40, n);
    check("seqB_coll_lat", n, 13);
    check("seqB_coll_idx0", cur_idx, 0);

    // Reset pulled mid-ASSERT clears everything, including the table.
    reset = 0; step();
    check("seqC_irq", interrupt, 0);
    check("seqC_fired", fired_cnt, 0);
    reset = 1;
    for (int k = 0; k < 4; k++) step();
    check("seqC_table_cleared", interrupt, 0);

    // Watchdog: drops after TOUT cycles when built in, waits otherwise.
    do_reset();
    cfg(0, 32'h3010, 1);
    idle_inputs(); step();
    macroscopic_pc = 32'h3010; step();
    idle_inputs();
    for (int k = 0; k < TOUT - 1; k++) step();
    check("seqD_hold", interrupt, 1);
    step();
    check("seqD_expire_irq", interrupt, !TO_EN);
    check("seqD_expire_tout", timeout, TO_EN);
    check("seqD_fired", fired_cnt, 0);
    do_reset();
    cfg(0, 32'h3010, 1);
    idle_inputs(); step();
    macroscopic_pc = 32'h3010; step();
    idle_inputs();
    for (int k = 0; k < TOUT - 1; k++) step();
    m_int_addr = ACKA; m_int_byteen = 4'hf; step();
    check("seqD_ack_at_expiry", fired_cnt, 1);
    check("seqD_ack_tout", timeout, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      int r;
      reset          = ($urandom_range(0, 499) != 0);
      sched_en       = ($urandom_range(0, 39) != 0);
      macroscopic_pc = 32'h3000 + ($urandom_range(0, 3) << 4) + $urandom_range(0, 3);
      cfg_we         = ($urandom_range(0, 11) == 0);
      cfg_idx        = 2'($urandom_range(0, 3));
      cfg_pc         = 32'h3000 + ($urandom_range(0, 3) << 4) + $urandom_range(0, 3);
      cfg_valid      = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 7);
      case (r)
        0:       begin m_int_addr = ACKA | $urandom_range(0, 3); m_int_byteen = 4'($urandom_range(1, 15)); end
        1:       begin m_int_addr = 32'h7f24; m_int_byteen = 4'hf; end
        2:       begin m_int_addr = ACKA; m_int_byteen = 4'h0; end
        default: begin m_int_addr = $urandom; m_int_byteen = 4'h0; end
      endcase
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
